// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer and its helpers.
package pll_seq_pkg;

    localparam int unsigned TIMER_W = 24;
    localparam int unsigned RETRY_W = 8;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_SETTLE    = 2'd2,
        ST_RUN       = 2'd3
    } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status bits; output lags input by two clocks.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: HOLD -> WAIT_LOCK -> SETTLE -> RUN with one shared down-counter.
// Define PLL_SEQ_TIMEOUT_EN to build the WAIT_LOCK timeout and the saturating retry counter.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = 500,
    parameter int unsigned LOCK_TIMEOUT  = 500000,
    parameter int unsigned SETTLE_CYCLES = 50000
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked_in,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam logic [TIMER_W-1:0] LD_HOLD   = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LD_WAIT   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] LD_SETTLE = TIMER_W'(SETTLE_CYCLES - 1);

    pll_state_e         r_state;
    pll_state_e         w_state_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic               w_timer_zero;
    logic               w_locked_s;
    logic               w_lost_set;
    logic               r_sys_rst;
    logic               r_ready;
    logic               r_lock_lost;
    logic               w_sys_rst_nxt;
    logic               w_ready_nxt;
`ifdef PLL_SEQ_TIMEOUT_EN
    logic               w_retry_inc;
    logic [RETRY_W-1:0] r_retry;
`endif

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked_in),
        .q   (w_locked_s)
    );

    assign w_timer_zero = (r_timer == '0);

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state     <= ST_HOLD;
            r_timer     <= LD_HOLD;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_sys_rst   <= w_sys_rst_nxt;
            r_ready     <= w_ready_nxt;
            r_lock_lost <= r_lock_lost | w_lost_set;
        end
    end

    // relock_req is checked first so it overrides timeouts and the RUN lock-drop flag
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_lost_set  = 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
        w_retry_inc = 1'b0;
`endif
        if (relock_req) begin
            w_state_nxt = ST_HOLD;
            w_timer_nxt = LD_HOLD;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (w_timer_zero) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_timer_nxt = LD_WAIT;
                    end else begin
                        w_timer_nxt = r_timer - 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_state_nxt = ST_SETTLE;
                        w_timer_nxt = LD_SETTLE;
                    end
`ifdef PLL_SEQ_TIMEOUT_EN
                    else if (w_timer_zero) begin
                        w_retry_inc = 1'b1;
                        w_state_nxt = ST_HOLD;
                        w_timer_nxt = LD_HOLD;
                    end else begin
                        w_timer_nxt = r_timer - 1'b1;
                    end
`endif
                end
                ST_SETTLE: begin
                    if (!w_locked_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_timer_nxt = LD_WAIT;
                    end else if (w_timer_zero) begin
                        w_state_nxt = ST_RUN;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        w_lost_set  = 1'b1;
                        w_state_nxt = ST_HOLD;
                        w_timer_nxt = LD_HOLD;
                    end
                end
                default: begin
                    w_state_nxt = ST_HOLD;
                    w_timer_nxt = LD_HOLD;
                end
            endcase
        end
    end

    // sys_rst/ready are registered from the next state so they track r_state exactly
    always_comb begin
        w_sys_rst_nxt = (w_state_nxt != ST_RUN);
        w_ready_nxt   = (w_state_nxt == ST_RUN);
        pll_rst       = (r_state == ST_HOLD);
    end

`ifdef PLL_SEQ_TIMEOUT_EN
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_retry <= '0;
        end else if (w_retry_inc && (r_retry != '1)) begin
            r_retry <= r_retry + 1'b1;
        end
    end

    assign retry_cnt = r_retry;
`else
    assign retry_cnt = '0;
`endif

    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;

endmodule
